// File: rtl/decomp_recompose.sv
// rtl/decomp_recompose.sv - rebuilds r = (r1*2*gamma2 + r0) mod q from a decomposed pair
// Two-stage pipeline (sum + range check, then modular fold) with valid/ready on both sides.
module decomp_recompose (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  sec_lvl,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  r1,
  input  logic [18:0] r0,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [22:0] dout,
  output logic        range_err,
  input  logic        err_clr
);

  localparam logic signed [26:0] Q         = 27'sd8380417;
  localparam logic        [22:0] Q_LO      = 23'd8380417;
  localparam logic signed [26:0] GAMMA2_L0 = 27'sd261888;
  localparam logic signed [26:0] GAMMA2_L2 = 27'sd95232;

  logic                adv;
  logic                lvl2;
  logic signed [26:0]  gamma2;
  logic signed [26:0]  alpha;
  logic        [5:0]   r1_max;
  logic signed [26:0]  r0_ext;
  logic signed [26:0]  r1_ext;
  logic signed [26:0]  in_sum;
  logic                in_err;

  logic                s1_v;
  logic                s1_err;
  logic signed [26:0]  s1_sum;
  logic        [22:0]  dout_next;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    lvl2   = (sec_lvl == 3'b010);
    gamma2 = lvl2 ? GAMMA2_L2 : GAMMA2_L0;
    alpha  = gamma2 <<< 1;
    r1_max = lvl2 ? 6'd43 : 6'd15;
    r0_ext = {{8{r0[18]}}, r0};
    r1_ext = {21'd0, r1};
    in_sum = r1_ext * alpha + r0_ext;
    // -gamma2 itself is accepted so the q-1 corner (r1 = 0) round-trips
    in_err = (r1 > r1_max) || (r0_ext > gamma2) || (r0_ext < -gamma2);
  end

  // Only the low 23 bits matter once the sum is folded into 0..q-1
  always_comb begin
    dout_next = s1_sum[22:0];
    if (s1_err)
      dout_next = 23'd0;
    else if (s1_sum < 0)
      dout_next = s1_sum[22:0] + Q_LO;
    else if (s1_sum >= Q)
      dout_next = s1_sum[22:0] - Q_LO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s1_err    <= 1'b0;
      s1_sum    <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
      range_err <= 1'b0;
    end else begin
      if (adv) begin
        s1_v <= in_valid;
        if (in_valid) begin
          s1_sum <= in_sum;
          s1_err <= in_err;
        end
        out_valid <= s1_v;
        if (s1_v)
          dout <= dout_next;
      end
      if (adv && s1_v && s1_err)
        range_err <= 1'b1;
      else if (err_clr)
        range_err <= 1'b0;
    end
  end

endmodule

// File: doc/decomp_recompose.md
# decomp_recompose

Streaming inverse of the Dilithium decompose stage, paired with `decomp_map1`. It takes a decomposed coefficient pair (high part `r1`, centred low part `r0`) and rebuilds the coefficient r = (r1·2γ2 + r0) mod q, with q = 8380417. It sits on the verify/reconstruction path downstream of coefficient unpacking. It is a two-stage pipeline with valid/ready flow control on both sides, accepting one coefficient per cycle.

## Interface
- `Q`, 8380417, Dilithium modulus.
- `GAMMA2_L0`, 261888, γ2 for security level code 3'b000, equal to (q-1)/32.
- `GAMMA2_L2`, 95232, γ2 for security level code 3'b010, equal to (q-1)/88.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sec_lvl`  in  3  security level, sampled with each accepted input. 3'b010 selects level 2; every other code selects level 0.
- `in_valid`  in  1  `r1`, `r0` and `sec_lvl` are valid this cycle.
- `in_ready`  out  1  the block accepts the input this cycle.
- `r1`  in  6  high part, unsigned.
- `r0`  in  19  low part, two's complement.
- `out_valid`  out  1  `dout` holds a result.
- `out_ready`  in  1  the consumer takes `dout` this cycle.
- `dout`  out  23  reconstructed coefficient, in the range 0..Q-1.
- `range_err`  out  1  sticky flag; set on any accepted out-of-range `r1` or `r0`.
- `err_clr`  in  1  synchronous clear of `range_err`.

## Operation
- α = 2·γ2. Level 0 uses α = 523776 with legal `r1` 0..15. Level 2 uses α = 190464 with legal `r1` 0..43.
- Legal `r0` is -γ2+1..γ2 for the selected level. The value -γ2 is also legal, to cover the q-1 corner case where `r1` = 0.
- Stage 1, on accept:
  - s1_sum = r1·α + r0 (signed, 27 bits).
  - s1_err = range violation.
  - s1_v = 1.
- Stage 2, on advance:
  - If s1_err = 1, `dout` = 0.
  - Otherwise, if s1_sum < 0, `dout` = s1_sum + Q.
  - Otherwise, if s1_sum ≥ Q, `dout` = s1_sum − Q.
  - Otherwise, `dout` = s1_sum.
  - `out_valid` takes s1_v.
- Advance enable: adv = !out_valid || out_ready. Both stages shift together when adv = 1; `in_ready` = adv, combinational.
- When adv = 1 and `in_valid` = 0, s1_v is loaded with 0, which inserts a bubble.
- When adv = 0, all pipeline registers hold. `dout` and `out_valid` stay stable until the consumer accepts.
- `range_err` is set in the cycle stage 2 captures an errored sample, and is cleared by `err_clr`. If both happen in the same cycle, set wins.
- An errored sample still occupies its slot and produces `dout` = 0 with `out_valid` = 1. Ordering and count of samples are preserved.

## Timing
- Reset values: `out_valid` = 0, `dout` = 0, `range_err` = 0, s1_v = 0, s1_sum = 0, s1_err = 0.
- `in_ready` = 1 immediately after reset.
- Latency: a sample accepted at edge N shows `out_valid` = 1 after edge N+1. This holds whenever `out_ready` is held high.
- Throughput: 1 sample per cycle while `out_ready` = 1.
- Backpressure:
  - When `out_ready` = 0 and `out_valid` = 1, `in_ready` drops in the same cycle.
  - At most 2 samples are in flight.
  - No sample is lost or duplicated.
- Simultaneous accept and emit: when `out_valid` & `out_ready` & `in_valid` are all 1, stage 2 takes the stage-1 sample and stage 1 takes the new input on the same edge.
- `sec_lvl` changes between samples take effect per sample; no flush is needed.
- Reset asserted mid-stream clears both stages immediately. In-flight samples are discarded.
- `dout` is don't-care-free: it always holds the last emitted value, or 0 after reset.

## Test plan
- Reset, then level 0, `r1` = 2, `r0` = -261887 with `out_ready` = 1 → `dout` = 785665 with `out_valid` two edges after accept; `range_err` = 0.
- Level 0, `r1` = 0, `r0` = -1 → `dout` = 8380416 (wrap through +Q). Then `r1` = 15, `r0` = 261888 → `dout` = 8118528.
- Level 2 back-to-back stream: (`r1` = 1, `r0` = -95231) → 95233; (43, 95232) → 8285184; (0, 1) → 1. Outputs arrive on consecutive cycles with no gaps.
- Backpressure:
  - Stimulus: 5 level-0 samples (`r1` = 0..4, `r0` = 1), with `out_ready` toggled 1,0,0,1,0,1… → outputs 1, 523777, 1047553, 1571329, 2095105, in order.
  - `in_ready` is low exactly when `out_valid` = 1 and `out_ready` = 0.
  - `dout` is stable while stalled.
- Range error:
  - Level 0, `r1` = 16, `r0` = 0 → `dout` = 0 and `range_err` = 1, sticky across later good samples.
  - Pulsing `err_clr` returns `range_err` to 0.
  - Level 2, `r1` = 44 → same behaviour.
- Assert `rst_n` low while 2 samples are in flight and `out_ready` = 0 → `out_valid` = 0 and `dout` = 0 asynchronously. After release, the first new sample (level 0, `r1` = 1, `r0` = 0) → 523776.
